// File: rtl/wb_dual_master_arbiter_if.sv
// Wishbone bus bundle used on both sides of wb_dual_master_arbiter.
// The master modport is the view of whoever initiates cycles; the slave
// modport is the view of whoever answers them. Each master-facing port of
// the arbiter uses the slave modport. The shared downstream port uses the
// master modport.
interface wb_dual_master_arbiter_if;
  logic [31:0] adr;
  logic [31:0] dat_w;   // write data, master to slave
  logic [31:0] dat_r;   // read data, slave to master
  logic        we;
  logic [3:0]  sel;
  logic        stb;
  logic        cyc;
  logic        ack;

  modport master (
    output adr, dat_w, we, sel, stb, cyc,
    input  dat_r, ack
  );

  modport slave (
    input  adr, dat_w, we, sel, stb, cyc,
    output dat_r, ack
  );
endinterface

// File: rtl/wb_dual_master_arbiter.sv
// Two-master Wishbone arbiter with round-robin grant of whole bus cycles.
// It is built for the Atom core's instruction and data buses sharing one
// single-port slave.
// Optional feature: define ARB_WATCHDOG_EN to add a stall watchdog. The
// watchdog ends a cycle the slave has not acked within TIMEOUT_CYCLES,
// and signals the owner through its err output.
module wb_dual_master_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,   // synchronous, active-low
  wb_dual_master_arbiter_if.slave  m0,
  wb_dual_master_arbiter_if.slave  m1,
  wb_dual_master_arbiter_if.master s,
  output logic                     m0_err_o,
  output logic                     m1_err_o,
  output logic [1:0]               gnt_o
);

  // The watchdog timer is 16 bits wide, so the limit must fit.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t     state_q;
  logic       last_q;   // master that won the most recent grant
  logic [1:0] gnt_q;

  logic req0, req1;
  logic timeout;

  assign req0  = m0.cyc & m0.stb;
  assign req1  = m1.cyc & m1.stb;
  assign gnt_o = gnt_q;

`ifdef ARB_WATCHDOG_EN
  logic [15:0] timer_q;
  logic        owner_stb;

  assign owner_stb = (state_q == OWN0) ? m0.stb :
                     (state_q == OWN1) ? m1.stb : 1'b0;
  assign timeout   = (state_q != IDLE) && (timer_q == 16'(TIMEOUT_CYCLES));

  // Stall timer: cleared while idle (so it starts at zero on each grant), on
  // every slave ack and when it terminates a cycle. It counts only while the
  // owner strobes without an ack.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      timer_q <= '0;
    end else if (state_q == IDLE || s.ack || timeout) begin
      timer_q <= '0;
    end else if (owner_stb) begin
      timer_q <= timer_q + 16'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Ownership FSM: grants whole bus cycles and alternates on ties.
  // Ownership ends when the owner drops cyc or the watchdog fires.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 && (!req1 || last_q)) begin
            state_q <= OWN0;
            gnt_q   <= 2'b01;
            last_q  <= 1'b0;
          end else if (req1) begin
            state_q <= OWN1;
            gnt_q   <= 2'b10;
            last_q  <= 1'b1;
          end
        end
        OWN0: begin
          if (!m0.cyc || timeout) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
          end
        end
        OWN1: begin
          if (!m1.cyc || timeout) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 2'b00;
        end
      endcase
    end
  end

  // Bus routing: connect the slave to the owning master. The non-owner sees
  // zeros. A watchdog termination masks the strobe, the cycle and the ack.
  always_comb begin
    s.adr    = '0;
    s.dat_w  = '0;
    s.we     = 1'b0;
    s.sel    = '0;
    s.stb    = 1'b0;
    s.cyc    = 1'b0;
    m0.dat_r = '0;
    m0.ack   = 1'b0;
    m1.dat_r = '0;
    m1.ack   = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    case (state_q)
      OWN0: begin
        s.adr    = m0.adr;
        s.dat_w  = m0.dat_w;
        s.we     = m0.we;
        s.sel    = m0.sel;
        s.stb    = m0.stb & ~timeout;
        s.cyc    = m0.cyc & ~timeout;
        m0.dat_r = s.dat_r;
        m0.ack   = s.ack & ~timeout;
        m0_err_o = timeout;
      end
      OWN1: begin
        s.adr    = m1.adr;
        s.dat_w  = m1.dat_w;
        s.we     = m1.we;
        s.sel    = m1.sel;
        s.stb    = m1.stb & ~timeout;
        s.cyc    = m1.cyc & ~timeout;
        m1.dat_r = s.dat_r;
        m1.ack   = s.ack & ~timeout;
        m1_err_o = timeout;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Directed bench for wb_dual_master_arbiter. It covers reset, a single read,
// round-robin alternation, block hold, write routing, stb drop and the
// watchdog (or, without ARB_WATCHDOG_EN, an unbounded stall).
module tb_wb_dual_master_arbiter;

  logic       clk;
  logic       rst_n;
  logic       m0_err, m1_err;
  logic [1:0] gnt;

  int ncmp = 0;
  int nerr = 0;

  wb_dual_master_arbiter_if m0_bus ();
  wb_dual_master_arbiter_if m1_bus ();
  wb_dual_master_arbiter_if s_bus ();

  wb_dual_master_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .m0       (m0_bus),
    .m1       (m1_bus),
    .s        (s_bus),
    .m0_err_o (m0_err),
    .m1_err_o (m1_err),
    .gnt_o    (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Move past the next rising edge; registered state is then stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_bus.adr = 32'h0000_0100; m0_bus.dat_w = '0; m0_bus.we = 1'b0;
    m0_bus.sel = 4'hF; m0_bus.stb = 1'b1; m0_bus.cyc = 1'b1;
    m1_bus.adr = 32'h0000_0200; m1_bus.dat_w = '0; m1_bus.we = 1'b0;
    m1_bus.sel = 4'hF; m1_bus.stb = 1'b1; m1_bus.cyc = 1'b1;
    s_bus.ack = 1'b0; s_bus.dat_r = 32'h1234_5678;

    // Reset held for 3 edges with both masters requesting
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_sstb", 32'(s_bus.stb), 32'h0);
      chk("rst_scyc", 32'(s_bus.cyc), 32'h0);
      chk("rst_ack", {30'h0, m1_bus.ack, m0_bus.ack}, 32'h0);
      chk("rst_err", {30'h0, m1_err, m0_err}, 32'h0);
    end

    // First tie after reset goes to m0
    rst_n = 1'b1;
    step();
    chk("rel_gnt", 32'(gnt), 32'h1);
    chk("rel_sstb", 32'(s_bus.stb), 32'h1);
    chk("rel_sadr", s_bus.adr, 32'h0000_0100);
    m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0;
    m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0;
    step();
    chk("rel_idle", 32'(gnt), 32'h0);

    // Single read by m1, acked after 2 wait cycles
    m1_bus.adr = 32'h0400_0010; m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1;
    step();
    chk("rd_gnt", 32'(gnt), 32'h2);
    chk("rd_sadr", s_bus.adr, 32'h0400_0010);
    chk("rd_noack", 32'(m1_bus.ack), 32'h0);
    step();
    step();
    // Ack arrives in the same cycle m1 drops cyc
    s_bus.ack = 1'b1; s_bus.dat_r = 32'hDEAD_BEEF;
    m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0;
    settle();
    chk("rd_ack", 32'(m1_bus.ack), 32'h1);
    chk("rd_dat", m1_bus.dat_r, 32'hDEAD_BEEF);
    chk("rd_m0ack", 32'(m0_bus.ack), 32'h0);
    chk("rd_m0dat", m0_bus.dat_r, 32'h0);
    step();
    s_bus.ack = 1'b0;
    settle();
    chk("rd_idle", 32'(gnt), 32'h0);
    chk("rd_scyc", 32'(s_bus.cyc), 32'h0);

    // Round-robin with both masters requesting single-beat cycles
    m0_bus.adr = 32'h0000_0100; m1_bus.adr = 32'h0000_0200;
    m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1;
    m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_gnt", 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("rr_sadr", s_bus.adr, (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
      if (i == 3) break;
      s_bus.ack = 1'b1;
      if (i % 2 == 0) begin m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0; end
      else            begin m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0; end
      step();
      s_bus.ack = 1'b0;
      chk("rr_gap", 32'(gnt), 32'h0);
      m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1;
      m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1;
    end

    // Block hold: m1 owns for 4 acked beats while m0 waits
    for (int i = 0; i < 4; i++) begin
      s_bus.ack = 1'b1;
      settle();
      chk("blk_gnt", 32'(gnt), 32'h2);
      chk("blk_m1ack", 32'(m1_bus.ack), 32'h1);
      chk("blk_m0ack", 32'(m0_bus.ack), 32'h0);
      step();
    end
    s_bus.ack = 1'b0;
    m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0;
    step();
    chk("blk_idle", 32'(gnt), 32'h0);
    step();
    chk("blk_m0gnt", 32'(gnt), 32'h1);

    // Write routing while m0 owns
    m0_bus.we = 1'b1; m0_bus.dat_w = 32'h0000_00A5; m0_bus.sel = 4'b0001;
    s_bus.dat_r = 32'h1234_5678;
    settle();
    chk("wr_sdat", s_bus.dat_w, 32'h0000_00A5);
    chk("wr_ssel", 32'(s_bus.sel), 32'h1);
    chk("wr_swe", 32'(s_bus.we), 32'h1);
    chk("wr_m1dat", m1_bus.dat_r, 32'h0);
    chk("wr_m1ack", 32'(m1_bus.ack), 32'h0);
    s_bus.ack = 1'b1;
    m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0;
    settle();
    chk("wr_m0ack", 32'(m0_bus.ack), 32'h1);
    step();
    s_bus.ack = 1'b0;
    m0_bus.we = 1'b0; m0_bus.sel = 4'hF;
    settle();
    chk("wr_idle_adr", s_bus.adr, 32'h0);
    chk("wr_idle_we", 32'(s_bus.we), 32'h0);

    // Owner drops stb but keeps cyc: grant retained
    m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1;
    step();
    chk("stb_gnt", 32'(gnt), 32'h1);
    m0_bus.stb = 1'b0;
    settle();
    chk("stb_sstb", 32'(s_bus.stb), 32'h0);
    chk("stb_scyc", 32'(s_bus.cyc), 32'h1);
    step();
    chk("stb_hold", 32'(gnt), 32'h1);
    m0_bus.cyc = 1'b0;
    step();
    chk("stb_idle", 32'(gnt), 32'h0);

    // Stalled slave: m0 granted, m1 waits
    m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1;
    step();
    chk("wd_gnt", 32'(gnt), 32'h1);
    m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1;
`ifdef ARB_WATCHDOG_EN
    for (int i = 0; i < 8; i++) begin
      settle();
      chk("wd_noerr", 32'(m0_err), 32'h0);
      chk("wd_scyc", 32'(s_bus.cyc), 32'h1);
      step();
    end
    chk("wd_err", 32'(m0_err), 32'h1);
    chk("wd_m1err", 32'(m1_err), 32'h0);
    chk("wd_scyc_drop", 32'(s_bus.cyc), 32'h0);
    chk("wd_sstb_drop", 32'(s_bus.stb), 32'h0);
    step();
    chk("wd_idle", 32'(gnt), 32'h0);
    chk("wd_err_once", 32'(m0_err), 32'h0);
    step();
    chk("wd_m1gnt", 32'(gnt), 32'h2);
`else
    for (int i = 0; i < 12; i++) begin
      settle();
      chk("st_noerr", {30'h0, m1_err, m0_err}, 32'h0);
      chk("st_gnt", 32'(gnt), 32'h1);
      step();
    end
    chk("st_scyc", 32'(s_bus.cyc), 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
